// File: rtl/types_pkg.sv
// Shared types for the issue stage: decoded op format, issue bus and the
// opcode-to-functional-unit mapping.
package types;

  localparam int FU_CNT  = 3;
  localparam int REG_CNT = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BU  = 2'd1,
    FU_LSU = 2'd2
  } e_functional_unit;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        has_rd;
    logic        has_rs1;
    logic        has_rs2;
    logic [31:0] imm;
  } operation_specification;

  typedef struct packed {
    logic                   valid;
    e_functional_unit       rs_id;
    operation_specification op;
  } issue_bus;

  // Unknown opcodes fall through to the ALU so the queue never wedges.
  function automatic e_functional_unit opcode_to_fu(input bit [6:0] opcode);
    case (opcode)
      OPC_BRANCH:          return FU_BU;
      OPC_LOAD, OPC_STORE: return FU_LSU;
      default:             return FU_ALU;
    endcase
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous FIFO of decoded ops with a combinational head view so the
// head can be evaluated in the cycle after it is written.
module issue_fifo
  import types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  operation_specification wr_data,
  input  logic                   rd_en,
  output operation_specification rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [CW-1:0]          count
);

  operation_specification mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_fire, rd_fire;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  // Flush wins over both ports; the pointers wrap naturally at DEPTH.
  assign wr_fire = wr_en && !full && !flush;
  assign rd_fire = rd_en && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_fire) - CW'(rd_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/issue_unit.sv
// In-order issue stage: op queue, pending-destination scoreboard, hazard
// checks and a registered issue bus towards the reservation stations.
module issue_unit
  import types::*;
#(
  parameter int DEPTH   = 4,
  parameter int REG_CNT = types::REG_CNT,
  parameter int RS_CNT  = types::FU_CNT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  operation_specification   dec_op,
  input  logic [RS_CNT-1:0]        rs_busy,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic                     flush,
  output issue_bus                 issue,
  output logic [$clog2(DEPTH):0]   queue_count
);

  operation_specification head_op;
  logic                   fifo_full, fifo_empty;
  logic                   can_issue;
  logic                   src_ok, waw_ok;
  e_functional_unit       head_fu;

  logic [REG_CNT-1:0] scoreboard_q, scoreboard_d;
  issue_bus           issue_q, issue_d;

  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (dec_valid),
    .wr_data (dec_op),
    .rd_en   (can_issue),
    .rd_data (head_op),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (queue_count)
  );

  assign dec_ready = !fifo_full;
  assign issue     = issue_q;
  assign head_fu   = opcode_to_fu(head_op.opcode);

  // A register is usable if it is x0, not pending, or written back this cycle.
  function automatic logic reg_free(input logic [4:0] r,
                                    input logic [REG_CNT-1:0] sb,
                                    input logic wbv,
                                    input logic [4:0] wbr);
    return (r == 5'd0) || !sb[r] || (wbv && (wbr == r));
  endfunction

  always_comb begin
    src_ok = (!head_op.has_rs1 || reg_free(head_op.rs1, scoreboard_q, wb_valid, wb_rd)) &&
             (!head_op.has_rs2 || reg_free(head_op.rs2, scoreboard_q, wb_valid, wb_rd));
    waw_ok = !head_op.has_rd || reg_free(head_op.rd, scoreboard_q, wb_valid, wb_rd);
    can_issue = !fifo_empty && src_ok && waw_ok && !rs_busy[head_fu] && !flush;
  end

  // Set after clear so a new producer of the same register wins.
  always_comb begin
    scoreboard_d = scoreboard_q;
    if (flush) begin
      scoreboard_d = '0;
    end else begin
      if (wb_valid && (wb_rd != 5'd0)) scoreboard_d[wb_rd] = 1'b0;
      if (can_issue && head_op.has_rd && (head_op.rd != 5'd0)) scoreboard_d[head_op.rd] = 1'b1;
    end
    scoreboard_d[0] = 1'b0;
  end

  always_comb begin
    issue_d       = issue_q;
    issue_d.valid = 1'b0;
    if (can_issue) begin
      issue_d.valid = 1'b1;
      issue_d.rs_id = head_fu;
      issue_d.op    = head_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scoreboard_q <= '0;
      issue_q      <= '0;
    end else begin
      scoreboard_q <= scoreboard_d;
      issue_q      <= issue_d;
    end
  end

endmodule

// File: tb/tb_issue_unit.sv
// Randomized scoreboard bench for issue_unit against a queue-based model.
module tb_issue_unit;
  import types::*;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   dec_valid;
  logic                   dec_ready;
  operation_specification dec_op;
  logic [2:0]             rs_busy;
  logic                   wb_valid;
  logic [4:0]             wb_rd;
  logic                   flush;
  issue_bus               issue;
  logic [2:0]             queue_count;

  issue_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_op      (dec_op),
    .rs_busy     (rs_busy),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .issue       (issue),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    operation_specification op;
    int                     fu;
    int                     due;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  operation_specification mq[$];
  exp_t                   expq[$];
  bit [31:0]              pend;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_fu(input logic [6:0] opc);
    if (opc == 7'b1100011) return 1;
    if (opc == 7'b0000011 || opc == 7'b0100011) return 2;
    return 0;
  endfunction

  function automatic bit avail(input logic [4:0] r, input bit wbv, input logic [4:0] wbr);
    return (r == 0) || !pend[r] || (wbv && wbr == r);
  endfunction

  function automatic operation_specification mk(input logic [6:0] opc, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input bit hrd, input bit hrs1, input bit hrs2);
    operation_specification o;
    o.opcode = opc; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2;
    o.has_rd = hrd; o.has_rs1 = hrs1; o.has_rs2 = hrs2;
    o.imm = $urandom;
    return o;
  endfunction

  function automatic operation_specification rand_op();
    logic [6:0] opc;
    case ($urandom_range(0, 6))
      0: opc = 7'b0110011;
      1: opc = 7'b0010011;
      2: opc = 7'b1100011;
      3: opc = 7'b0000011;
      4: opc = 7'b0100011;
      5: opc = 7'b0110111;
      default: opc = 7'($urandom);
    endcase
    return mk(opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  // One cycle: check occupancy, drive inputs, advance the reference model.
  task automatic step(input bit dv, input operation_specification op, input logic [2:0] busy,
                      input bit wbv, input logic [4:0] wbr, input bit fl);
    int n;
    int f;
    bit iss;
    operation_specification h;
    @(negedge clk); #1;
    chk("queue_count", 64'(queue_count), 64'(mq.size()));
    chk("dec_ready", 64'(dec_ready), 64'(mq.size() < DEPTH));
    dec_valid = dv; dec_op = op; rs_busy = busy; wb_valid = wbv; wb_rd = wbr; flush = fl;
    n = mq.size();
    iss = 0;
    f = 0;
    if (fl) begin
      mq.delete();
      pend = '0;
    end else begin
      if (n > 0) begin
        h = mq[0];
        f = ref_fu(h.opcode);
        iss = (!h.has_rs1 || avail(h.rs1, wbv, wbr)) && (!h.has_rs2 || avail(h.rs2, wbv, wbr)) &&
              (!h.has_rd || avail(h.rd, wbv, wbr)) && !busy[f];
      end
      if (iss) begin
        expq.push_back('{op: h, fu: f, due: cyc + 1});
        void'(mq.pop_front());
      end
      if (wbv && wbr != 0) pend[wbr] = 1'b0;
      if (iss && h.has_rd && h.rd != 0) pend[h.rd] = 1'b1;
      if (dv && n < DEPTH) mq.push_back(op);
    end
  endtask

  task automatic idle(input int k, input logic [2:0] busy);
    for (int i = 0; i < k; i++) step(0, '0, busy, 0, 0, 0);
  endtask

  task automatic wb(input logic [4:0] r);
    step(0, '0, 3'b000, 1, r, 0);
  endtask

  task automatic async_reset();
    @(negedge clk); #1;
    dec_valid = 0; flush = 0; wb_valid = 0; rs_busy = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_issue", 64'(issue), 64'd0);
    chk("rst_count", 64'(queue_count), 64'd0);
    chk("rst_ready", 64'(dec_ready), 64'd1);
    mq.delete(); expq.delete(); pend = '0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the expected queue whenever the DUT presents an issue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (issue.valid) begin
          if (expq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL issue_unexpected: got op %h expected none (cycle %0d)", issue.op, cyc);
          end else begin
            e = expq.pop_front();
            chk("issue_op", 64'(issue.op), 64'(e.op));
            chk("issue_rs_id", 64'(issue.rs_id), 64'(e.fu));
            chk("issue_cycle", 64'(cyc), 64'(e.due));
          end
        end else if (expq.size() > 0 && expq[0].due <= cyc) begin
          e = expq.pop_front();
          vectors++; miscompares++;
          $display("FAIL issue_missed: got valid=0 expected op %h due %0d (cycle %0d)", e.op, e.due, cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] r;
    int pl[$];
    rst_n = 1'b0; dec_valid = 0; dec_op = '0; rs_busy = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    pend = '0;
    #3;
    chk("rst_issue", 64'(issue), 64'd0);
    chk("rst_count", 64'(queue_count), 64'd0);
    chk("rst_ready", 64'(dec_ready), 64'd1);
    @(negedge clk); #1; rst_n = 1'b1;

    // ADD r3 then SW reading r3: SW waits for writeback of r3
    step(1, mk(7'b0110011, 3, 1, 2, 1, 1, 1), 3'b000, 0, 0, 0);
    step(1, mk(7'b0100011, 0, 3, 4, 0, 1, 1), 3'b000, 0, 0, 0);
    idle(3, 3'b000);
    wb(3);
    idle(3, 3'b000);

    // branch unit busy blocks BEQ and the ALU op behind it
    step(1, mk(7'b1100011, 0, 1, 2, 0, 1, 1), 3'b010, 0, 0, 0);
    step(1, mk(7'b0010011, 6, 1, 0, 1, 1, 0), 3'b010, 0, 0, 0);
    idle(3, 3'b010);
    idle(3, 3'b000);
    wb(6);

    // fill while all stations busy; fifth op must be dropped
    for (int i = 0; i < 5; i++) step(1, rand_op(), 3'b111, 0, 0, 0);
    chk("full_count", 64'(queue_count), 64'(DEPTH));
    chk("full_ready", 64'(dec_ready), 64'd0);
    idle(6, 3'b000);
    for (int i = 1; i < 8; i++) wb(5'(i));

    // rd=0/rs1=0, then rd=5 issued in the same cycle as a writeback of r5
    step(1, mk(7'b0110011, 0, 0, 0, 1, 1, 0), 3'b000, 0, 0, 0);
    step(1, mk(7'b0110011, 5, 0, 0, 1, 0, 0), 3'b000, 0, 0, 0);
    step(1, mk(7'b0110011, 7, 5, 0, 1, 1, 0), 3'b000, 1, 5, 0);
    idle(4, 3'b000);
    wb(5);
    idle(3, 3'b000);
    wb(7);

    // flush with three queued ops and a concurrent decoder offer
    for (int i = 0; i < 3; i++) step(1, rand_op(), 3'b111, 0, 0, 0);
    step(1, rand_op(), 3'b000, 0, 0, 1);
    chk("flush_issue_valid", 64'(issue.valid), 64'd0);
    idle(2, 3'b000);

    // random traffic with an asynchronous reset in the middle
    for (int k = 0; k < 1600; k++) begin
      if (k == 800) async_reset();
      pl.delete();
      for (int i = 1; i < 8; i++) if (pend[i]) pl.push_back(i);
      if (pl.size() > 0 && $urandom_range(0, 1) == 1) r = 5'(pl[$urandom_range(0, pl.size() - 1)]);
      else r = 5'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, rand_op(),
           ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
           $urandom_range(0, 9) < 4, r, $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 40; i++) wb(5'(i % 8));
    idle(3, 3'b000);
    chk("expected_drained", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- In-order issue stage between the decoder and the reservation stations.
- Buffers decoded operation_specification entries in a small FIFO and tracks pending destination registers in a 32-entry scoreboard.
- Maps each opcode to a functional unit and drives issue_bus when operands are free and the target station is idle.
- Writeback clears scoreboard bits.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- REG_CNT, 32, architectural registers tracked by the scoreboard
- RS_CNT, types::FU_CNT (3), number of reservation stations; rs_id = e_functional_unit index

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decoder offers an op
- dec_ready  out  1  queue can accept (not full)
- dec_op  in  operation_specification  decoded op
- rs_busy  in  RS_CNT  per-station busy; rs_busy[i]=1 blocks issue to station i
- wb_valid  in  1  a result is written back this cycle
- wb_rd  in  5  register being written back
- flush  in  1  discard queue and scoreboard (branch mispredict)
- issue  out  issue_bus  registered issue to reservation stations
- queue_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; queue_count=0; dec_ready=1.
  - Scoreboard all 0.
  - issue.valid=0, issue.rs_id=0, issue.op all-zero.
- Enqueue: on dec_valid && dec_ready at a rising edge. dec_ready = (queue_count != DEPTH) and does not depend on same-cycle dequeue.
- FU map from head op opcode:
  - 0110011, 0010011 → ALU(0)
  - 1100011 → BU(1)
  - 0000011, 0100011 → LSU(2)
  - any other opcode → ALU(0)
- Operand checks on head op h:
  - src_ok = for each of rs1 (has_rs1) and rs2 (has_rs2): reg==0, or scoreboard[reg]==0, or (wb_valid && wb_rd==reg) (same-cycle writeback bypass).
  - waw_ok = !has_rd, or rd==0, or scoreboard[rd]==0, or (wb_valid && wb_rd==rd).
- can_issue = head valid && src_ok && waw_ok && !rs_busy[fu] && !flush.
- Issue:
  - On can_issue, the head is dequeued at the edge.
  - Next cycle, issue.valid=1, issue.rs_id=fu, issue.op=head.
  - Otherwise issue.valid=0 next cycle and issue.op/rs_id hold their last value.
  - Strict in-order: a stalled head blocks all younger ops.
- Latency: op enqueued at edge E becomes head and is evaluated in the cycle after E. Earliest issue.valid is 2 cycles after dec_valid is accepted. Sustained throughput is 1 op/cycle with no hazards.
- Scoreboard:
  - On issue with has_rd && rd!=0, set bit rd.
  - On wb_valid && wb_rd!=0, clear bit wb_rd.
  - Same rd set and cleared in the same cycle → set wins (the newer producer).
  - Bit 0 is never set.
- FIFO:
  - Simultaneous enqueue and dequeue keeps queue_count unchanged.
  - Pointers wrap modulo DEPTH.
  - Dequeue while empty never happens (head must be valid).
- Flush (synchronous):
  - At the edge, FIFO is emptied, scoreboard is cleared, and issue.valid=0 next cycle.
  - flush has priority over enqueue: dec_op that cycle is dropped, even if dec_valid && dec_ready.
- Reset mid-operation: all state returns to the reset values immediately; no partial issue.
- rs_busy is sampled only in the decision cycle. A station going busy after issue.valid is registered does not retract the issue.

Decomposition:
- Add to the types package:
  - opcode localparams OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_LOAD, OPC_STORE
  - function opcode_to_fu(bit [6:0]) returning e_functional_unit
  - localparam REG_CNT=32
- One sub-module: issue_fifo, a parameterised synchronous FIFO of operation_specification with full/empty/count. issue_unit holds the scoreboard, hazard logic and issue register.

Test Plan:
- Reset then single ADD (opc 0110011, rs1=1, rs2=2, rd=3), idle stations → issue.valid=1 two cycles after acceptance, rs_id=0; scoreboard[3]=1.
- ADD rd=3 then SW (0100011, rs1=3, rs2=4) → SW stalls until wb_valid/wb_rd=3. SW issues with rs_id=2 in the cycle after the wb (bypass applies in the wb cycle itself).
- rs_busy=3'b010 with BEQ (1100011) at head and ALU op behind → nothing issues (in-order). Drop rs_busy[1] → BEQ issues rs_id=1, then the ALU op next cycle.
- Fill 4 ops while rs_busy=3'b111 → queue_count=4, dec_ready=0, fifth dec_valid ignored. Release → 4 consecutive issue.valid cycles, queue_count back to 0.
- Op with rd=0 and rs1=0 → issues with no scoreboard change. Same-cycle issue of rd=5 and wb_rd=5 → scoreboard[5]=1 afterwards.
- Queue holding 3 ops plus flush with dec_valid=1 → next cycle queue_count=0, scoreboard=0, issue.valid=0. Async rst_n pulse mid-stream → outputs return to reset values without waiting for clk.
